// File: rtl/mc_control.sv
// Multi-cycle MIPS-style control FSM: sequences FETCH/DECODE and the
// per-class execute states, driving datapath strobes and mux selects.
//
// Ports:
//   clk, rst         clock and async active-high reset
//   opcode, funct    instruction fields, held stable from DECODE onward
//   zero             ALU zero flag (branch gating is done in the datapath)
//   pc_write .. alu_src_a   1-bit strobes and selects
//   alu_src_b, pc_source    2-bit mux selects
//   alu_op           ALU op (NOP=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 NOR=6)
//   state            current FSM state, for debug
//
// Build option: define MC_IMM_LOGIC_EN to add andi/ori/xori via I_EXEC.

module mc_control #(
  parameter int ALU_OP_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [3:0]          state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_t;

  localparam logic [ALU_OP_W-1:0] ALU_NOP = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_NOR = ALU_OP_W'(6);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t r_state;
  state_t w_next;

  logic w_is_lw;
  logic w_is_sw;
  logic w_is_mem;
  logic w_is_rtype;
  logic w_is_beq;
  logic w_is_j;
  logic w_is_imm;
  logic w_is_imm_logic;
  logic w_funct_ok;
  logic w_unused;

  logic [ALU_OP_W-1:0] w_r_alu_op;
  logic [ALU_OP_W-1:0] w_i_alu_op;

  // Branch resolution uses zero in the datapath, not here.
  assign w_unused = zero;

  assign w_is_lw    = (opcode == OP_LW);
  assign w_is_sw    = (opcode == OP_SW);
  assign w_is_mem   = w_is_lw | w_is_sw;
  assign w_is_rtype = (opcode == OP_RTYPE);
  assign w_is_beq   = (opcode == OP_BEQ);
  assign w_is_j     = (opcode == OP_J);

`ifdef MC_IMM_LOGIC_EN
  assign w_is_imm_logic = (opcode == OP_ANDI)
                        | (opcode == OP_ORI)
                        | (opcode == OP_XORI);
`else
  assign w_is_imm_logic = 1'b0;
`endif

  assign w_is_imm = (opcode == OP_ADDI) | w_is_imm_logic;

  // funct -> ALU op; NOP marks an illegal funct
  always_comb begin
    w_r_alu_op = ALU_NOP;
    case (funct)
      6'h20:   w_r_alu_op = ALU_ADD;
      6'h22:   w_r_alu_op = ALU_SUB;
      6'h24:   w_r_alu_op = ALU_AND;
      6'h25:   w_r_alu_op = ALU_OR;
      6'h26:   w_r_alu_op = ALU_XOR;
      6'h27:   w_r_alu_op = ALU_NOR;
      default: w_r_alu_op = ALU_NOP;
    endcase
  end

  assign w_funct_ok = (w_r_alu_op != ALU_NOP);

  always_comb begin
    w_i_alu_op = ALU_ADD;
`ifdef MC_IMM_LOGIC_EN
    case (opcode)
      OP_ANDI: w_i_alu_op = ALU_AND;
      OP_ORI:  w_i_alu_op = ALU_OR;
      OP_XORI: w_i_alu_op = ALU_XOR;
      default: w_i_alu_op = ALU_ADD;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  assign state = r_state;

  always_comb begin
    w_next        = S_FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = ALU_NOP;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // speculative branch target: PC + (imm << 2)
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        unique case (1'b1)
          w_is_mem:                 w_next = S_MEM_ADDR;
          w_is_rtype && w_funct_ok: w_next = S_R_EXEC;
          w_is_beq:                 w_next = S_BRANCH;
          w_is_j:                   w_next = S_JUMP;
          w_is_imm:                 w_next = S_I_EXEC;
          default:                  w_next = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        w_next    = w_is_lw ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        w_next   = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        w_next    = S_FETCH;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = w_r_alu_op;
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        w_next        = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        w_next    = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = w_i_alu_op;
        w_next    = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter ALU_OP_W, default 5, SHALL set the width of alu_op.
REQ-002 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 opcode  input  6  SHALL be the instruction opcode, held stable by the datapath IR from DECODE onward.
REQ-005 funct  input  6  SHALL be the R-type function field, held stable with opcode.
REQ-006 zero  input  1  SHALL be the ALU result-equals-zero flag.
REQ-007 pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  SHALL be the datapath strobes and selects.
REQ-008 alu_src_b, pc_source  output  2 each  SHALL be the ALU-B and next-PC mux selects.
REQ-009 alu_op  output  ALU_OP_W  SHALL use the ALU encoding: NOP=00, ADD=01, SUB=02, AND=03, OR=04, XOR=05, NOR=06.
REQ-010 state  output  4  SHALL expose the current FSM state for debug.

Function
REQ-011 All outputs SHALL be Moore outputs decoded from the state register, except alu_op in R_EXEC, which is also decoded from funct.
REQ-012 States and encodings SHALL be FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
REQ-013 FETCH SHALL assert mem_read, ir_write and pc_write, and SHALL drive i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD and pc_source=00. It SHALL always go to DECODE.
REQ-014 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=ADD to compute the branch target. Its next state SHALL be:
  - MEM_ADDR for lw (0x23) or sw (0x2B);
  - R_EXEC for opcode 0x00 with a legal funct;
  - BRANCH for beq (0x04);
  - JUMP for j (0x02);
  - I_EXEC for addi (0x08);
  - FETCH for any other opcode.
REQ-015 Legal R-type funct values SHALL be 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR and 0x27 NOR. An illegal funct SHALL return to FETCH from DECODE with no writes.
REQ-016 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=ADD, then go to MEM_RD for lw or MEM_WR for sw.
REQ-017 MEM_RD SHALL assert mem_read with i_or_d=1 and go to MEM_WB. MEM_WB SHALL assert reg_write with mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-018 MEM_WR SHALL assert mem_write with i_or_d=1 and go to FETCH.
REQ-019 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op mapped from funct, then go to R_WB. R_WB SHALL assert reg_write with reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-020 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1 and pc_source=01, then go to FETCH. The PC update SHALL occur only when zero=1, as gated by the datapath.
REQ-021 JUMP SHALL assert pc_write with pc_source=10 and go to FETCH.
REQ-022 I_EXEC SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=ADD (or the REQ-028 op), then go to I_WB. I_WB SHALL assert reg_write with reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-023 Any output not listed for a state SHALL be 0; alu_op not listed SHALL be NOP.
REQ-024 Cycles per instruction SHALL be: lw 5; sw, R-type and addi 4; beq and j 3; illegal 2. Unused encodings 12-15 SHALL go to FETCH on the next edge.

Reset
REQ-025 While rst=1, state SHALL be FETCH, and rst SHALL take effect asynchronously, including mid-instruction.
REQ-026 During reset, outputs SHALL equal the FETCH decode: pc_write=1, mem_read=1, ir_write=1, alu_src_b=01, alu_op=ADD, all others 0. Datapath registers are reset concurrently, so these strobes have no effect.
REQ-027 After rst deasserts, the first rising edge SHALL move FETCH to DECODE.

Configuration
REQ-028 With MC_IMM_LOGIC_EN defined, DECODE SHALL also route andi (0x0C), ori (0x0D) and xori (0x0E) to I_EXEC, where alu_op SHALL be AND, OR and XOR respectively, with alu_src_b=10. Without the macro, these opcodes SHALL be illegal and return to FETCH.

Verification
REQ-029 Reset mid-R_EXEC (state=6), then release → state=0 immediately while rst=1; alu_op=01 and pc_write=1 during reset; state=1 after the first edge.
REQ-030 lw (opcode 0x23) → state sequence 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-031 R-type, funct 0x27 → alu_op=06 in state 6; reg_dst=1 and reg_write=1 in state 7; back to FETCH after 4 cycles.
REQ-032 beq with zero=0, then with zero=1 → both follow 0,1,8,0 with pc_write_cond=1, pc_source=01 and alu_op=02 in state 8.
REQ-033 Opcode 0x3F, then R-type funct 0x00 → each follows 0,1,0 with mem_write=reg_write=0 throughout.
REQ-034 Opcode 0x0D with MC_IMM_LOGIC_EN → 0,1,10,11,0 with alu_op=04 in state 10. Without the macro → 0,1,0.
